// File: rtl/prog_mem_responder_if.sv
// ---------------------------------------------------------------------------
// prog_mem_responder_if
//   Bundles the instruction-fetch bus and the image load port of the program
//   memory responder.
//   master : processor core / loader side (drives requests and load bytes)
//   slave  : prog_mem_responder side (returns instruction, status)
//   Signals:
//     rom_cs, rom_rd      fetch chip select and read strobe
//     program_addr[15:0]  byte address of the fetch
//     load_en             image load write enable
//     load_addr[7:0]      image load address
//     load_data[7:0]      image load byte
//     instruction[7:0]    registered fetched byte
//     data_valid          one-cycle strobe marking fresh instruction data
//     addr_err            out-of-range fetch flag, qualified by data_valid
//     busy                responder is processing a fetch
// ---------------------------------------------------------------------------
interface prog_mem_responder_if;
  logic        rom_cs;
  logic        rom_rd;
  logic [15:0] program_addr;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic [7:0]  instruction;
  logic        data_valid;
  logic        addr_err;
  logic        busy;

  modport master (
    output rom_cs, rom_rd, program_addr, load_en, load_addr, load_data,
    input  instruction, data_valid, addr_err, busy
  );

  modport slave (
    input  rom_cs, rom_rd, program_addr, load_en, load_addr, load_data,
    output instruction, data_valid, addr_err, busy
  );
endinterface : prog_mem_responder_if

// File: rtl/prog_mem_responder.sv
// ---------------------------------------------------------------------------
// prog_mem_responder
//   256 x 8 program ROM image with a wait-stated fetch port and an
//   independent byte load port.
//   A fetch is accepted in IDLE when rom_cs and rom_rd are both high; the
//   address is latched, WAIT_STATES extra cycles are spent in WAIT, and the
//   array is read on the edge entering DRIVE. DRIVE lasts one cycle, with
//   data_valid high. Dropping rom_cs in WAIT aborts the fetch.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset (array contents are kept)
//     bus    prog_mem_responder_if.slave (fetch bus + load port + status)
//   Parameter:
//     WAIT_STATES  extra wait cycles per read, 0..15
// ---------------------------------------------------------------------------
module prog_mem_responder #(
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  prog_mem_responder_if.slave  bus
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  wait_cnt;
  logic [15:0] addr_q;
  logic [7:0]  mem [256];
  logic        accept;
  logic        enter_drive;

  assign accept      = (state == S_IDLE) && bus.rom_cs && bus.rom_rd;
  assign enter_drive = (state_next == S_DRIVE) && (state != S_DRIVE);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic. rom_rd is only looked at for acceptance; once in WAIT
  // only rom_cs can abort the fetch.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_WAIT;
      S_WAIT: begin
        if (!bus.rom_cs)        state_next = S_IDLE;
        else if (wait_cnt == '0) state_next = S_DRIVE;
      end
      S_DRIVE: state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic from state.
  always_comb begin
    bus.busy = (state != S_IDLE);
  end

  // Fetch datapath: address latch, wait counter and registered outputs.
  // The array is sampled here on the DRIVE-entry edge, so a load in the same
  // edge lands after the read (old byte returned) while earlier loads during
  // WAIT are visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt        <= '0;
      addr_q          <= '0;
      bus.instruction <= 8'h00;
      bus.data_valid  <= 1'b0;
      bus.addr_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q   <= bus.program_addr;
            wait_cnt <= WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (!bus.rom_cs)         wait_cnt <= '0;
          else if (wait_cnt != '0) wait_cnt <= wait_cnt - 4'd1;
        end
        default: ;
      endcase

      bus.data_valid <= enter_drive;

      if (enter_drive) begin
        if (addr_q[15:8] != 8'h00) begin
          bus.instruction <= 8'hFF;
          bus.addr_err    <= 1'b1;
        end else begin
          bus.instruction <= mem[addr_q[7:0]];
          bus.addr_err    <= 1'b0;
        end
      end
    end
  end

  // Image load port, active in every state including reset.
  // NOTE: the array is deliberately not reset; reset must preserve the loaded
  // image, and a resettable array would not map onto RAM.
  always_ff @(posedge clk) begin
    if (bus.load_en) mem[bus.load_addr] <= bus.load_data;
  end

endmodule : prog_mem_responder

// File: tb/tb_prog_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_prog_mem_responder
//   Directed bench for prog_mem_responder. Two instances share clk/reset:
//   dut2 (WAIT_STATES=2) and dut0 (WAIT_STATES=0). Inputs change 1 ns after
//   the rising edge and outputs are sampled at the same point, so every
//   "tick" advances exactly one edge.
// ---------------------------------------------------------------------------
module tb_prog_mem_responder;

  logic clk;
  logic reset;
  int   n_total;
  int   n_bad;

  prog_mem_responder_if if2 ();
  prog_mem_responder_if if0 ();

  prog_mem_responder #(.WAIT_STATES(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2.slave)
  );

  prog_mem_responder #(.WAIT_STATES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load2(input logic [7:0] a, input logic [7:0] d);
    if2.load_en   = 1'b1;
    if2.load_addr = a;
    if2.load_data = d;
    tick();
    if2.load_en   = 1'b0;
  endtask

  // Read on dut2: acceptance edge, then edges 1..3. A load to the read
  // address is placed on edge ld_edge (0 = no load). Returns after the
  // DRIVE-entry edge so the caller can check the strobed outputs.
  task automatic read2(input string tag, input logic [15:0] a,
                       input int ld_edge, input logic [7:0] ld_data);
    if2.rom_cs       = 1'b1;
    if2.rom_rd       = 1'b1;
    if2.program_addr = a;
    tick();
    check({tag, "_busy_acc"}, 16'(if2.busy), 16'h1);
    if2.rom_rd = 1'b0;   // rom_rd drop in WAIT must not abort
    for (int e = 1; e <= 3; e++) begin
      if2.load_en   = (e == ld_edge);
      if2.load_addr = a[7:0];
      if2.load_data = ld_data;
      tick();
      if2.load_en = 1'b0;
      if (e < 3) check({tag, "_dv_early"}, 16'(if2.data_valid), 16'h0);
    end
    if2.rom_cs = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b1;
    {if2.rom_cs, if2.rom_rd, if2.load_en} = '0;
    {if0.rom_cs, if0.rom_rd, if0.load_en} = '0;
    if2.program_addr = '0; if2.load_addr = '0; if2.load_data = '0;
    if0.program_addr = '0; if0.load_addr = '0; if0.load_data = '0;

    // Loads while in reset must land in the array.
    tick();
    load2(8'h10, 8'hA5);
    load2(8'h05, 8'h5A);
    load2(8'h20, 8'h11);
    if0.load_en = 1'b1; if0.load_addr = 8'h00; if0.load_data = 8'h3C;
    tick();
    if0.load_en = 1'b0;

    check("rst_instr", 16'(if2.instruction), 16'h00);
    check("rst_dv",    16'(if2.data_valid),  16'h0);
    check("rst_err",   16'(if2.addr_err),    16'h0);
    check("rst_busy",  16'(if2.busy),        16'h0);
    check("rst_busy0", 16'(if0.busy),        16'h0);

    reset = 1'b0;
    tick();

    // WAIT_STATES=2 latency: valid only after edge k+3.
    read2("ws2", 16'h0010, 0, 8'h00);
    check("ws2_dv",    16'(if2.data_valid),  16'h1);
    check("ws2_instr", 16'(if2.instruction), 16'hA5);
    check("ws2_err",   16'(if2.addr_err),    16'h0);
    check("ws2_busy",  16'(if2.busy),        16'h1);
    tick();
    check("ws2_dv_off",  16'(if2.data_valid),  16'h0);
    check("ws2_idle",    16'(if2.busy),        16'h0);
    check("ws2_hold",    16'(if2.instruction), 16'hA5);

    // WAIT_STATES=0: valid after edge k+1, busy for 2 cycles.
    if0.rom_cs = 1'b1; if0.rom_rd = 1'b1; if0.program_addr = 16'h0000;
    tick();
    if0.rom_rd = 1'b0;
    check("ws0_busy1", 16'(if0.busy),       16'h1);
    check("ws0_dv0",   16'(if0.data_valid), 16'h0);
    tick();
    if0.rom_cs = 1'b0;
    check("ws0_busy2", 16'(if0.busy),        16'h1);
    check("ws0_dv",    16'(if0.data_valid),  16'h1);
    check("ws0_instr", 16'(if0.instruction), 16'h3C);
    tick();
    check("ws0_idle",  16'(if0.busy),        16'h0);
    check("ws0_dv1",   16'(if0.data_valid),  16'h0);

    // Out-of-range fetch, then an in-range fetch clears addr_err.
    read2("oor", 16'h0105, 0, 8'h00);
    check("oor_dv",    16'(if2.data_valid),  16'h1);
    check("oor_instr", 16'(if2.instruction), 16'hFF);
    check("oor_err",   16'(if2.addr_err),    16'h1);
    tick();
    check("oor_err_hold", 16'(if2.addr_err), 16'h1);
    read2("inr", 16'h0005, 0, 8'h00);
    check("inr_instr", 16'(if2.instruction), 16'h5A);
    check("inr_err",   16'(if2.addr_err),    16'h0);
    tick();

    // Request held through DRIVE: re-accepted only one cycle after DRIVE.
    if2.rom_cs = 1'b1; if2.rom_rd = 1'b1; if2.program_addr = 16'h0010;
    tick();                                // accept, edge k
    repeat (3) tick();                     // edge k+3 -> DRIVE
    check("held_dv", 16'(if2.data_valid), 16'h1);
    tick();                                // edge k+4 -> IDLE
    check("held_idle", 16'(if2.busy), 16'h0);
    tick();                                // edge k+5 -> re-accepted
    check("held_reacc", 16'(if2.busy), 16'h1);

    // Abort by dropping rom_cs in WAIT.
    if2.rom_cs = 1'b0; if2.rom_rd = 1'b0;
    tick();
    check("abort_busy", 16'(if2.busy), 16'h0);
    for (int i = 0; i < 4; i++) begin
      check("abort_dv", 16'(if2.data_valid), 16'h0);
      tick();
    end
    check("abort_instr", 16'(if2.instruction), 16'hA5);

    // Reset during WAIT discards the read; array is preserved.
    if2.rom_cs = 1'b1; if2.rom_rd = 1'b1; if2.program_addr = 16'h0005;
    tick();
    if2.rom_rd = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rstw_instr", 16'(if2.instruction), 16'h00);
    check("rstw_dv",    16'(if2.data_valid),  16'h0);
    check("rstw_err",   16'(if2.addr_err),    16'h0);
    check("rstw_busy",  16'(if2.busy),        16'h0);
    reset = 1'b0;
    if2.rom_cs = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rstw_no_dv", 16'(if2.data_valid), 16'h0);
    end
    // First request after reset is accepted at the first qualifying edge.
    read2("post_rst", 16'h0010, 0, 8'h00);
    check("post_rst_instr", 16'(if2.instruction), 16'hA5);
    check("post_rst_dv",    16'(if2.data_valid),  16'h1);
    tick();

    // Load during WAIT is visible; load on the DRIVE-entry edge is not.
    read2("ldw", 16'h0020, 2, 8'h22);
    check("ldw_instr", 16'(if2.instruction), 16'h22);
    tick();
    read2("ldd", 16'h0020, 3, 8'h33);
    check("ldd_instr", 16'(if2.instruction), 16'h22);
    tick();
    read2("ldd_after", 16'h0020, 0, 8'h00);
    check("ldd_after_instr", 16'(if2.instruction), 16'h33);
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_prog_mem_responder

// File: doc/prog_mem_responder.md
PROG_MEM_RESPONDER -- requirements
Module: prog_mem_responder

Interface
REQ-001 Parameter: WAIT_STATES, default 2, number of extra wait cycles per read, legal range 0..15.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rom_cs  input  1  chip select from the processor core.
REQ-005 rom_rd  input  1  read strobe from the processor core.
REQ-006 program_addr  input  16  byte address of the instruction fetch.
REQ-007 load_en  input  1  write-enable for the image load port.
REQ-008 load_addr  input  8  image load address.
REQ-009 load_data  input  8  image load byte.
REQ-010 instruction  output  8  registered instruction byte returned to the core.
REQ-011 data_valid  output  1  high for exactly one cycle when instruction carries fresh read data.
REQ-012 addr_err  output  1  registered; qualifies the same cycle as data_valid; out-of-range fetch.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 Storage SHALL be a 256 x 8 array, indexed by the low 8 address bits.
REQ-015 A request SHALL be accepted only in IDLE, at an edge where rom_cs=1 and rom_rd=1; program_addr is latched at that edge.
REQ-016 FSM states SHALL be IDLE, WAIT and DRIVE; on acceptance IDLE->WAIT with the 4-bit wait counter loaded to WAIT_STATES.
REQ-017 In WAIT, at each edge: rom_cs=0 -> IDLE (abort, no data_valid); else counter=0 -> DRIVE; else counter decrements, stay WAIT.
REQ-018 DRIVE SHALL last exactly one cycle, then go to IDLE unconditionally.
REQ-019 Latency: acceptance at edge k -> data_valid=1 in the cycle after edge k+1+WAIT_STATES (WAIT_STATES=0 gives data_valid after edge k+1).
REQ-020 Throughput: at most one read per WAIT_STATES+3 cycles; requests held active through DRIVE are re-accepted only once back in IDLE.
REQ-021 instruction, data_valid and addr_err SHALL be loaded at the edge entering DRIVE; data_valid=1 only while in DRIVE.
REQ-022 instruction SHALL hold its last value outside DRIVE until the next DRIVE entry or reset.
REQ-023 Latched program_addr[15:8] != 0 -> instruction=0xFF, addr_err=1; otherwise instruction=mem[addr[7:0]], addr_err=0.
REQ-024 addr_err SHALL hold its value until the next DRIVE entry or reset.
REQ-025 The array SHALL be read at the edge entering DRIVE, not at acceptance; loads during WAIT to the target address are visible.
REQ-026 load_en=1 SHALL write load_data to mem[load_addr] at that edge, in any state, including during reset.
REQ-027 On a simultaneous load and DRIVE read of the same address, the read SHALL return the old byte (read-before-write).
REQ-028 rom_rd dropping during WAIT while rom_cs stays high SHALL NOT abort the read.
REQ-029 busy = (state != IDLE), combinational from state.

Reset
REQ-030 reset=1 at an edge SHALL force IDLE, wait counter 0, instruction=0x00, data_valid=0, addr_err=0, busy=0; this takes priority over every transition.
REQ-031 Reset mid-read (WAIT or DRIVE) SHALL discard the read; no data_valid is produced for it after reset release.
REQ-032 Reset SHALL NOT alter array contents.
REQ-033 The first request after reset SHALL be accepted at the first edge with reset=0, rom_cs=1 and rom_rd=1.

Verification
REQ-034 WAIT_STATES=2: load mem[0x10]=0xA5; request addr 0x0010 at edge k -> data_valid=1, instruction=0xA5, addr_err=0 after edge k+3 only.
REQ-035 WAIT_STATES=0: load mem[0x00]=0x3C; request addr 0x0000 at edge k -> instruction=0x3C, data_valid after edge k+1; busy high for 2 cycles.
REQ-036 Request addr 0x0105 -> instruction=0xFF, addr_err=1 with data_valid; a following read of 0x0005 clears addr_err.
REQ-037 Drop rom_cs in WAIT -> IDLE, no data_valid, instruction unchanged; reset asserted in WAIT -> all outputs 0, array contents preserved.
REQ-038 mem[0x20]=0x11; request 0x0020; write 0x22 there during WAIT -> 0x22 returned; repeat with the write on the DRIVE-entry edge -> old byte returned.
